// File: rtl/demux_scan_n_v.sv
// demux_scan_n_v: registered 1-of-N active-low decoder/demux with three-input chip select and auto-scan.
// Optional build macro DEMUX_SCAN_BLANK_EN inserts one blank cycle ahead of every scan advance.
module demux_scan_n_v #(
   parameter int SEL_W = 4,
   parameter int N_OUT = 10,
   parameter int DWELL = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [SEL_W-1:0] i_sel,
   input  logic             i_cs,
   input  logic             i_n_cs_0,
   input  logic             i_n_cs_1,
   input  logic             i_mode,
   input  logic             i_load,
   output logic [N_OUT-1:0] o_y,
   output logic [SEL_W-1:0] o_idx,
   output logic             o_wrap
);

   localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_OUT - 1);

   typedef enum logic [1:0] {ST_OFF, ST_DIRECT, ST_SCAN} state_t;

   state_t           r_state, w_state_nxt;
   logic [SEL_W-1:0] r_idx, w_idx_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_cur;
   logic [N_OUT-1:0] r_y, w_y_nxt;
   logic [SEL_W-1:0] r_oidx, w_oidx_nxt;
   logic             r_wrap, w_wrap_nxt;
   logic             w_en, w_sel_ok, w_at_last, w_adv;
   logic [SEL_W-1:0] w_sel_clip, w_idx_inc;
`ifdef DEMUX_SCAN_BLANK_EN
   logic             r_blank, w_blank_nxt;
`endif

   // Codes with no matching output leave every line high, like the 7442 on invalid BCD.
   function automatic logic [N_OUT-1:0] f_decode(input logic [SEL_W-1:0] idx);
      logic [N_OUT-1:0] y;
      y = '1;
      for (int k = 0; k < N_OUT; k++) begin
         if (idx == SEL_W'(k)) y[k] = 1'b0;
      end
      return y;
   endfunction

   assign w_en       = i_cs & ~i_n_cs_0 & ~i_n_cs_1;
   assign w_sel_ok   = ({1'b0, i_sel} < (SEL_W + 1)'(N_OUT));
   assign w_sel_clip = w_sel_ok ? i_sel : '0;
   assign w_at_last  = (r_idx == IDX_LAST);
   assign w_idx_inc  = w_at_last ? '0 : r_idx + 1'b1;
   // Dwell always restarts when scan is entered straight from direct decode.
   assign w_cnt_cur  = (r_state == ST_DIRECT) ? '0 : r_cnt;

   always_comb begin
      if (!w_en)        w_state_nxt = ST_OFF;
      else if (!i_mode) w_state_nxt = ST_DIRECT;
      else              w_state_nxt = ST_SCAN;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      w_idx_nxt  = r_idx;
      w_cnt_nxt  = r_cnt;
      w_y_nxt    = '1;
      w_oidx_nxt = r_oidx;
      w_wrap_nxt = 1'b0;
      w_adv      = 1'b0;
`ifdef DEMUX_SCAN_BLANK_EN
      w_blank_nxt = 1'b0;
`endif
      case (w_state_nxt)
         ST_OFF: begin
            w_y_nxt = '1;
         end
         ST_DIRECT: begin
            w_idx_nxt  = w_sel_clip;
            w_cnt_nxt  = '0;
            w_y_nxt    = f_decode(i_sel);
            w_oidx_nxt = i_sel;
         end
         default: begin
            if (i_load) begin
               w_idx_nxt  = w_sel_clip;
               w_cnt_nxt  = '0;
               w_y_nxt    = f_decode(w_sel_clip);
               w_oidx_nxt = w_sel_clip;
`ifdef DEMUX_SCAN_BLANK_EN
            end else if (r_blank) begin
               w_adv = 1'b1;
            end else if (w_cnt_cur == CNT_LAST) begin
               w_blank_nxt = 1'b1;
               w_cnt_nxt   = w_cnt_cur;
               w_oidx_nxt  = r_idx;
`else
            end else if (w_cnt_cur == CNT_LAST) begin
               w_adv = 1'b1;
`endif
            end else begin
               w_cnt_nxt  = w_cnt_cur + 1'b1;
               w_y_nxt    = f_decode(r_idx);
               w_oidx_nxt = r_idx;
            end
         end
      endcase
      if (w_adv) begin
         w_idx_nxt  = w_idx_inc;
         w_cnt_nxt  = '0;
         w_y_nxt    = f_decode(w_idx_inc);
         w_oidx_nxt = w_idx_inc;
         w_wrap_nxt = w_at_last;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_OFF;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_y     <= '1;
         r_oidx  <= '0;
         r_wrap  <= 1'b0;
`ifdef DEMUX_SCAN_BLANK_EN
         r_blank <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_y     <= w_y_nxt;
         r_oidx  <= w_oidx_nxt;
         r_wrap  <= w_wrap_nxt;
`ifdef DEMUX_SCAN_BLANK_EN
         r_blank <= w_blank_nxt;
`endif
      end
   end

   assign o_y    = r_y;
   assign o_idx  = r_oidx;
   assign o_wrap = r_wrap;

endmodule
